// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-FIFO drain port of uart_rx_param.
//   rx_data    FIFO head word (first-word-fall-through)
//   rx_valid   FIFO not empty
//   fifo_count current number of FIFO entries
//   rx_pop     consumer takes the head word this cycle
// master = receiver side, slave = consumer (command decoder) side.
interface uart_rx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]          rx_data;
  logic                          rx_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          rx_pop;

  modport master (output rx_data, rx_valid, fifo_count, input rx_pop);
  modport slave  (input rx_data, rx_valid, fifo_count, output rx_pop);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with false-start rejection,
// sticky framing/parity/overrun flags and a small FWFT receive FIFO.
//   clk, rst   clock / synchronous active-high reset
//   RX         asynchronous serial line, idles high
//   clr_err    clear sticky error flags (a same-cycle set wins)
//   rxq        FIFO drain port (rx_data, rx_valid, fifo_count, rx_pop)
//   frame_err  sticky: a stop bit sampled low
//   parity_err sticky: parity mismatch
//   overrun    sticky: good word dropped, FIFO full
//   rx_busy    line state machine not idle
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic RX,
  input  logic clr_err,
  uart_rx_param_if.master rxq,
  output logic frame_err,
  output logic parity_err,
  output logic overrun,
  output logic rx_busy
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_LD   = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LD   = CW'(HALF_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam logic          PEN       = (PARITY_EN != 0);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // two-flop synchroniser, idle-high reset value
  logic rx_m, rx_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 stop_idx, stop_n;
  logic                 fe_acc, fe_n, pe_acc, pe_n;
  logic                 done, fe_cur, sample;

  assign sample = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      stop_idx <= 1'b0;
      fe_acc   <= 1'b0;
      pe_acc   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      sh       <= sh_n;
      stop_idx <= stop_n;
      fe_acc   <= fe_n;
      pe_acc   <= pe_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = sample ? cnt : cnt - 1'b1;
    bit_n   = bit_idx;
    sh_n    = sh;
    stop_n  = stop_idx;
    fe_n    = fe_acc;
    pe_n    = pe_acc;
    done    = 1'b0;
    fe_cur  = fe_acc | ~rx_s;   // frame error including the current stop sample
    case (state)
      S_IDLE: if (!rx_s) begin
        cnt_n   = HALF_LD;
        state_n = S_START;
      end
      S_START: if (sample) begin
        if (!rx_s) begin
          cnt_n   = FULL_LD;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          state_n = S_IDLE;       // glitch, not a real start bit
        end
      end
      S_DATA: if (sample) begin
        sh_n  = {rx_s, sh[DATA_BITS-1:1]};
        cnt_n = FULL_LD;
        bit_n = bit_idx + 1'b1;
        if (bit_idx == LAST_BIT) begin
          state_n = PEN ? S_PARITY : S_STOP;
          stop_n  = 1'b0;
          fe_n    = 1'b0;
          pe_n    = 1'b0;
        end
      end
      S_PARITY: if (sample) begin
        pe_n    = ((^sh) ^ rx_s) != ODD;
        cnt_n   = FULL_LD;
        state_n = S_STOP;
      end
      S_STOP: if (sample) begin
        if (stop_idx == LAST_STOP) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else begin
          stop_n = 1'b1;
          fe_n   = fe_cur;
          cnt_n  = FULL_LD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // receive FIFO
  logic [FIFO_DEPTH-1:0][DATA_BITS-1:0] mem;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          done_ok, pop_ok, full, push, ovr_set;

  assign done_ok = done & ~fe_cur & ~pe_acc;
  assign pop_ok  = rxq.rx_pop & rxq.rx_valid;
  assign full    = (count == DEPTH);
  // a same-cycle pop frees the slot, so a full FIFO still accepts the word
  assign push    = done_ok & (~full | pop_ok);
  assign ovr_set = done_ok & full & ~pop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= sh;
        wp      <= wp + 1'b1;
      end
      if (pop_ok) rp <= rp + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (done & fe_cur) | (frame_err  & ~clr_err);
      parity_err <= (done & pe_acc) | (parity_err & ~clr_err);
      overrun    <= ovr_set         | (overrun    & ~clr_err);
    end
  end

  assign rxq.rx_data    = mem[rp];
  assign rxq.rx_valid   = (count != '0);
  assign rxq.fifo_count = count;
  assign rx_busy        = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic rst, rx0, rx1, clr0, clr1;
  logic fe0, pe0, ov0, bz0, fe1, pe1, ov1, bz1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) q0 ();
  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) q1 ();

  // 8N1
  uart_rx_param #(.CLK_FREQ(50000000), .BAUD_RATE(5000000), .DATA_BITS(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .RX(rx0), .clr_err(clr0), .rxq(q0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .rx_busy(bz0));

  // 8E1
  uart_rx_param #(.CLK_FREQ(50000000), .BAUD_RATE(5000000), .DATA_BITS(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .RX(rx1), .clr_err(clr1), .rxq(q1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .rx_busy(bz1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted pop must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && q0.rx_pop && q0.rx_valid) begin
      if (exp0.size() == 0) chk("sb0_unexpected_word", q0.rx_data, 32'hFFFF_FFFF);
      else chk("sb0_data", q0.rx_data, exp0.pop_front());
    end
    if (!rst && q1.rx_pop && q1.rx_valid) begin
      if (exp1.size() == 0) chk("sb1_unexpected_word", q1.rx_data, 32'hFFFF_FFFF);
      else chk("sb1_data", q1.rx_data, exp1.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // drive one line level for n clocks; always leaves time at posedge+1
  task automatic line(input int sel, input logic b, input int n);
    if (sel == 0) rx0 = b; else rx1 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par, input logic stp);
    line(sel, 1'b0, 10);
    for (int i = 0; i < 8; i++) line(sel, d[i], 10);
    if (sel == 1) line(sel, par, 10);
    line(sel, stp, 10);
  endtask

  task automatic pop(input int sel);
    if (sel == 0) q0.rx_pop = 1'b1; else q1.rx_pop = 1'b1;
    @(posedge clk); #1;
    q0.rx_pop = 1'b0;
    q1.rx_pop = 1'b0;
  endtask

  task automatic clr_pulse();
    clr0 = 1'b1; clr1 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0; clr1 = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    q0.rx_pop = 1'b0; q1.rx_pop = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", q0.rx_valid, 0);
    chk("rst_count", q0.fifo_count, 0);
    chk("rst_data", q0.rx_data, 0);
    chk("rst_flags", {fe0, pe0, ov0, bz0}, 0);
    rst = 1'b0;
    line(0, 1'b1, 5);

    // 0xA5: rx_valid rises the cycle after the stop sample
    d = 8'hA5;
    exp0.push_back(d);
    line(0, 1'b0, 10);
    for (int i = 0; i < 8; i++) line(0, d[i], 10);
    line(0, 1'b1, 7);
    chk("a5_valid_before_stop_sample", q0.rx_valid, 0);
    chk("a5_busy_in_stop", bz0, 1);
    @(posedge clk); #1;
    chk("a5_valid_after_stop_sample", q0.rx_valid, 1);
    chk("a5_head", q0.rx_data, 8'hA5);
    chk("a5_count", q0.fifo_count, 1);
    chk("a5_flags_busy", {fe0, pe0, ov0, bz0}, 0);
    line(0, 1'b1, 2);
    pop(0);
    chk("a5_valid_after_pop", q0.rx_valid, 0);

    // five back-to-back words into a four-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k * 8'h11);
      if (k <= 4) exp0.push_back(d);
      send_frame(0, d, 1'b0, 1'b1);
    end
    line(0, 1'b1, 3);
    chk("ovr_count", q0.fifo_count, 4);
    chk("ovr_flag", ov0, 1);
    chk("ovr_no_frame_err", {fe0, pe0}, 0);
    for (int k = 0; k < 4; k++) pop(0);
    chk("ovr_drained", q0.rx_valid, 0);
    clr_pulse();
    chk("ovr_cleared", ov0, 0);

    // false start: 3-clock low glitch
    line(0, 1'b0, 3);
    chk("fs_busy", bz0, 1);
    line(0, 1'b1, 7);
    chk("fs_idle", bz0, 0);
    chk("fs_no_push", q0.fifo_count, 0);
    chk("fs_no_flags", {fe0, pe0, ov0}, 0);

    // framing error
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    line(0, 1'b1, 20);
    chk("fe_flag", fe0, 1);
    chk("fe_no_push", q0.fifo_count, 0);
    clr_pulse();
    chk("fe_cleared", fe0, 0);

    // even parity: 0x07 has three ones, so parity bit 1 is correct
    send_frame(1, 8'h07, 1'b0, 1'b1);
    line(1, 1'b1, 5);
    chk("pe_flag", pe1, 1);
    chk("pe_no_push", q1.fifo_count, 0);
    exp1.push_back(8'h07);
    send_frame(1, 8'h07, 1'b1, 1'b1);
    line(1, 1'b1, 3);
    chk("pe_good_count", q1.fifo_count, 1);
    chk("pe_good_head", q1.rx_data, 8'h07);
    chk("pe_sticky", pe1, 1);
    pop(1);
    clr_pulse();
    chk("pe_cleared", pe1, 0);

    // reset mid-frame with a word sitting in the FIFO
    send_frame(0, 8'h99, 1'b0, 1'b1);
    line(0, 1'b1, 3);
    chk("pre_rst_count", q0.fifo_count, 1);
    d = 8'h5A;
    line(0, 1'b0, 10);
    for (int i = 0; i < 3; i++) line(0, d[i], 10);
    line(0, d[3], 5);
    chk("pre_rst_busy", bz0, 1);
    rst = 1'b1; rx0 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid_count", {q0.rx_valid, q0.fifo_count}, 0);
    chk("mid_rst_data", q0.rx_data, 0);
    chk("mid_rst_flags_busy", {fe0, pe0, ov0, bz0}, 0);
    line(0, 1'b1, 30);
    exp0.push_back(d);
    send_frame(0, d, 1'b0, 1'b1);
    line(0, 1'b1, 2);
    chk("post_rst_count", q0.fifo_count, 1);
    chk("post_rst_flags", {fe0, pe0, ov0}, 0);
    pop(0);
    line(0, 1'b1, 2);

    chk("sb0_all_consumed", exp0.size(), 0);
    chk("sb1_all_consumed", exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 / 19200-baud receiver in the controller-bridge path.
- Configurable clock/baud, data width, parity and stop-bit count.
- Adds false-start rejection, framing/parity/overrun error reporting, and a small first-word-fall-through FIFO.
- Drains received words to the command decoder without per-byte software handshaking.

Parameters:
- CLK_FREQ, 50000000: system clock frequency, Hz.
- BAUD_RATE, 19200: line rate, bits/s. BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division). HALF_DIV = BAUD_DIV/2.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits checked, 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active high.
- RX  in  1  asynchronous serial line; idles high.
- rx_pop  in  1  consume the FIFO head word this cycle.
- clr_err  in  1  clear the sticky error flags.
- rx_data  out  DATA_BITS  FIFO head word; valid when rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- frame_err  out  1  sticky: a stop bit was sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: a good word was dropped because the FIFO was full.
- rx_busy  out  1  state != IDLE.

Behaviour:
- Synchroniser: two flops on RX, both reset to 1. All logic uses the synchronised copy, rx_s.
- Reset (synchronous, any time, including mid-frame):
  - state = IDLE; FIFO flushed.
  - rx_valid=0, fifo_count=0, all error flags=0, rx_busy=0, rx_data=0.
- Baud counter: width $clog2(BAUD_DIV+1). Loads on state entry as stated below, then decrements once per clk. The sample point is the cycle in which the counter is 0.
- IDLE:
  - On rx_s==0: load HALF_DIV-1, go to START.
- START (mid-start-bit check):
  - At sample, rx_s==0: load BAUD_DIV-1, clear the bit index, go to DATA.
  - At sample, rx_s==1: false start; return to IDLE with no flags and no push.
- DATA:
  - Each sample shifts rx_s into the shift register MSB-side, so the first received bit lands at bit 0. Reload BAUD_DIV-1.
  - After DATA_BITS samples: go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - Sample once. Error if (XOR of data bits ^ parity bit) != PARITY_ODD. Go to STOP.
- STOP:
  - Take STOP_BITS samples, one bit period apart. Any low sample is a frame error.
  - The final stop sample is the frame-complete cycle:
    - Frame or parity error: set the corresponding sticky flag(s); word is discarded.
    - Otherwise, FIFO full and no pop this cycle: set overrun; word is discarded.
    - Otherwise: push the word.
  - Next state is IDLE. A start edge is detectable on the following cycle; no extra idle time is required.
- FIFO (first-word-fall-through):
  - rx_data always shows the head word. rx_pop with rx_valid=0 is ignored.
  - Simultaneous push and pop: both take effect, count unchanged. When full, the pop frees the slot so the push succeeds.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - Cleared by clr_err.
  - If clr_err and a set event occur in the same cycle, set wins.
- rx_pop and clr_err have no effect on the line state machine.

Test Plan:
- Timing override for all scenarios: CLK_FREQ=50000000, BAUD_RATE=5000000, giving BAUD_DIV=10 and HALF_DIV=5.
- 8N1, send 0xA5 -> rx_valid rises one cycle after the stop-bit sample, with rx_data=0xA5, fifo_count=1 and no flags. rx_pop -> rx_valid=0.
- Send 0x11, 0x22, 0x33, 0x44, 0x55 with no pops (FIFO_DEPTH=4) -> FIFO holds 0x11..0x44, overrun=1. Four pops return 0x11, 0x22, 0x33, 0x44 in order.
- RX low pulse of 3 clocks -> false start: no push, no flags, rx_busy back to 0 within 7 cycles.
- Frame 0x3C with stop bit driven low -> frame_err=1, nothing pushed. clr_err -> frame_err=0.
- PARITY_EN=1, PARITY_ODD=0, 0x07 sent with parity bit 0 -> parity_err=1, no push. Same word with parity bit 1 -> pushed, rx_data=0x07.
- Assert rst mid-data-bit of a frame -> next cycle all outputs 0 and FIFO empty. The following clean frame 0x5A is received correctly.
